// File: rtl/xy_lane_packer.sv
// Packs X-bit lane beats into X*Y-bit words and queues them D deep for the consumer.
// Optional per-beat parity output yp is enabled by defining XY_LANE_PACKER_PARITY_EN.
module xy_lane_packer #(
  parameter int unsigned X = 4,
  parameter int unsigned Y = 1,
  parameter int unsigned D = 2,
  localparam int unsigned CW = $clog2(Y + 1)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [X-1:0]      xa,
  input  logic [X-1:0][1:0] xc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [X*Y-1:0]    yb,
  output logic [CW-1:0]     ybeats,
  output logic [1:0]        st,
`ifdef XY_LANE_PACKER_PARITY_EN
  output logic [Y-1:0]      yp,
`endif
  output logic              err
);

  localparam int unsigned W  = X * Y;
  localparam int unsigned PW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned QW = $clog2(D + 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_FILL = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;

  logic [1:0]    st_d;
  logic [W-1:0]  pk, pk_d;
  logic [CW-1:0] n, n_d;
  logic          err_d;
  logic          lane_bad;
  logic          acc, push, pop, full, empty;

  logic [W-1:0]  qw [D];
  logic [CW-1:0] qn [D];
  logic [PW-1:0] wp, rp;
  logic [QW-1:0] cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (cnt == QW'(D));
  assign empty = (cnt == '0);
  assign acc   = in_valid && (st != S_HOLD);
  assign push  = (st == S_HOLD) && !full;
  assign pop   = !empty && out_ready;

  assign in_ready  = (st != S_HOLD);
  assign out_valid = !empty;
  assign yb        = empty ? '0 : qw[rp];
  assign ybeats    = empty ? '0 : qn[rp];

  // Any lane coded 2'b11 marks the beat as erroneous.
  always_comb begin
    lane_bad = 1'b0;
    for (int i = 0; i < int'(X); i++) begin
      if (xc[i] == 2'b11) lane_bad = 1'b1;
    end
  end

  // Next-state: beat write, word close, and release into the queue.
  always_comb begin
    st_d  = st;
    pk_d  = pk;
    n_d   = n;
    err_d = err;
    if (acc) begin
      for (int i = 0; i < int'(Y); i++) begin
        if (n == CW'(i)) pk_d[i*X +: X] = xa;
      end
      n_d = n + CW'(1);
      if (lane_bad) err_d = 1'b1;
    end
    case (st)
      S_IDLE: if (acc) st_d = ((n_d == CW'(Y)) || flush) ? S_HOLD : S_FILL;
      S_FILL: if ((acc && (n_d == CW'(Y))) || flush) st_d = S_HOLD;
      S_HOLD: if (push) begin
        st_d = S_IDLE;
        pk_d = '0;
        n_d  = '0;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      st  <= S_IDLE;
      pk  <= '0;
      n   <= '0;
      err <= 1'b0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      st  <= st_d;
      pk  <= pk_d;
      n   <= n_d;
      err <= err_d;
      if (push) wp <= ptr_inc(wp);
      if (pop)  rp <= ptr_inc(rp);
      if (push && !pop)      cnt <= cnt + QW'(1);
      else if (pop && !push) cnt <= cnt - QW'(1);
    end
  end

  // Queue storage needs no reset: it is only visible while cnt is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      qw[wp] <= pk;
      qn[wp] <= n;
    end
  end

`ifdef XY_LANE_PACKER_PARITY_EN
  logic [Y-1:0] par;
  logic [Y-1:0] qp [D];

  always_comb begin
    par = '0;
    for (int i = 0; i < int'(Y); i++) par[i] = ^pk[i*X +: X];
  end

  always_ff @(posedge clk) begin
    if (push) qp[wp] <= par;
  end

  assign yp = empty ? '0 : qp[rp];
`endif

endmodule
